// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx serializer between NREQ byte requesters. It arbitrates
// round-robin, accepts one byte per grant through a valid/ready handshake, and
// drives the tx_din/tx_start inputs of uart_tx. It then holds off the next
// grant until uart_tx reports tx_done_tick.
//
// Build option:
//   UART_ARB_ID_PREFIX_EN - each grant sends an ASCII header frame
//                           (8'h30 + grant_id) ahead of the payload frame.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high
//   req_valid    - [NREQ] requester i has a byte pending
//   req_data     - [NREQ*DBIT] requester i's byte at [i*DBIT +: DBIT]
//   req_ready    - [NREQ] one-cycle one-hot accept pulse
//   tx_start     - one-cycle start pulse to uart_tx
//   tx_din       - [DBIT] byte to uart_tx, stable from tx_start to done
//   tx_done_tick - end-of-frame tick from uart_tx
//   busy         - high from grant until the cycle after the final done tick
//   grant_id     - [GW] current or most recent granted requester
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int DBIT = 8,
    localparam int GW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

`ifdef UART_ARB_ID_PREFIX_EN
    typedef enum logic [2:0] {IDLE, HSEND, HWAIT, SEND, WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
`endif

    state_t state, state_n;

    logic [GW-1:0]   last_grant;
    logic            win_found;
    logic [GW-1:0]   win_id;
    logic [DBIT-1:0] win_data;

`ifdef UART_ARB_ID_PREFIX_EN
    logic [DBIT-1:0] payload;
    logic [7:0]      hdr_byte;
`endif

    // Circular search starting just after the last served requester, so the
    // requester served most recently ends up with the lowest priority.
    always_comb begin
        logic [GW-1:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NREQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign win_data = req_data[win_id*DBIT +: DBIT];

`ifdef UART_ARB_ID_PREFIX_EN
    assign hdr_byte = 8'h30 + 8'(win_id);
`endif

    // Next-state and start pulse
    always_comb begin
        state_n  = state;
        tx_start = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
`ifdef UART_ARB_ID_PREFIX_EN
                    state_n = HSEND;
`else
                    state_n = SEND;
`endif
                end
            end
`ifdef UART_ARB_ID_PREFIX_EN
            HSEND: begin
                tx_start = 1'b1;
                state_n  = HWAIT;
            end
            HWAIT: begin
                if (tx_done_tick) state_n = SEND;
            end
`endif
            SEND: begin
                tx_start = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Grant bookkeeping and transmit byte
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready  <= '0;
            tx_din     <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
`ifdef UART_ARB_ID_PREFIX_EN
            payload    <= '0;
`endif
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
`ifdef UART_ARB_ID_PREFIX_EN
                        tx_din  <= DBIT'(hdr_byte);
                        payload <= win_data;
`else
                        tx_din  <= win_data;
`endif
                        grant_id  <= win_id;
                        req_ready <= NREQ'(1) << win_id;
                        busy      <= 1'b1;
                    end
                end
`ifdef UART_ARB_ID_PREFIX_EN
                HWAIT: begin
                    // Payload goes out on the frame right after the header.
                    if (tx_done_tick) tx_din <= payload;
                end
`endif
                WAIT: begin
                    if (tx_done_tick) begin
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DBIT  = 8;
    localparam int GW    = 2;
    localparam int FRAME = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [31:0]      req_data;
    logic [NREQ-1:0]  req_ready;
    logic             tx_start;
    logic [DBIT-1:0]  tx_din;
    logic             tx_done_tick;
    logic             busy;
    logic [GW-1:0]    grant_id;

    logic model_tick  = 1'b0;
    logic manual_tick = 1'b0;
    assign tx_done_tick = model_tick | manual_tick;

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [GW-1:0]   id;
        logic [DBIT-1:0] data;
    } frame_t;
    frame_t exp_q[$];

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [31:0]     data;
        logic [GW-1:0]   exp_id;
        logic [DBIT-1:0] exp_byte;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected frames for one grant, in serial order.
    task automatic push_grant(input logic [GW-1:0] id, input logic [DBIT-1:0] b);
        frame_t f;
`ifdef UART_ARB_ID_PREFIX_EN
        f.id = id; f.data = 8'h30 + 8'(id);
        exp_q.push_back(f);
`endif
        f.id = id; f.data = b;
        exp_q.push_back(f);
    endtask

    task automatic wait_ready(output logic [NREQ-1:0] rr);
        rr = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                rr = req_ready;
                break;
            end
        end
        if (rr == 0) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got no req_ready required a pulse");
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) begin done = 1; break; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy stuck high, required low");
        end
    endtask

    // Simple uart_tx stand-in: a done tick FRAME cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (FRAME - 1) @(posedge clk);
                #1 model_tick = 1'b1;
                @(posedge clk);
                #1 model_tick = 1'b0;
            end
        end
    end

    // Scoreboard: every start pulse is compared with the next expected frame.
    int  cyc = 0;
    int  tick_cyc = 0;
    bit  have_tick = 0;
    bit  check_gap = 0;
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start: got tx_start with din %0h required none", tx_din);
                end else begin
                    f = exp_q.pop_front();
                    chk("tx_din", 32'(tx_din), 32'(f.data));
                    chk("grant_id", 32'(grant_id), 32'(f.id));
                    chk("busy_at_start", 32'(busy), 32'd1);
`ifndef UART_ARB_ID_PREFIX_EN
                    chk("ready_with_start", 32'(req_ready), 32'(4'b0001 << f.id));
`endif
                    if (check_gap && have_tick) begin
                        chk("idle_gap", 32'(cyc - tick_cyc), 32'd2);
                        have_tick = 0;
                    end
                end
            end
            if (tx_done_tick && busy) begin
                tick_cyc  = cyc;
                have_tick = 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        logic [NREQ-1:0] rr;

        vecs[0] = '{4'b0100, 32'h00A5_0000, 2'd2, 8'hA5};
        vecs[1] = '{4'b0011, 32'h0000_C33C, 2'd0, 8'h3C};
        vecs[2] = '{4'b0011, 32'h0000_C33C, 2'd1, 8'hC3};
        vecs[3] = '{4'b1001, 32'h7E00_0081, 2'd3, 8'h7E};
        vecs[4] = '{4'b1111, 32'h4433_2211, 2'd0, 8'h11};
        vecs[5] = '{4'b0001, 32'h0000_00FF, 2'd0, 8'hFF};
        vecs[6] = '{4'b1000, 32'h8000_0000, 2'd3, 8'h80};

        reset = 1'b1; req_valid = '0; req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tx_din", 32'(tx_din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single grants, round-robin pointer carried between vectors
        for (int i = 0; i < 7; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            push_grant(vecs[i].exp_id, vecs[i].exp_byte);
            wait_ready(rr);
            chk("vec_ready", 32'(rr), 32'(4'b0001 << vecs[i].exp_id));
            req_valid = '0;
            wait_idle();
        end

        // All four requesting, back to back with one idle cycle between frames
        check_gap = 1; have_tick = 0;
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        push_grant(0, 8'h11); push_grant(1, 8'h22); push_grant(2, 8'h33);
        push_grant(3, 8'h44); push_grant(0, 8'h11);
        for (int i = 0; i < 5; i++) wait_ready(rr);
        req_valid = '0;
        wait_idle();
        check_gap = 0;

        // Fairness: requester 1 holds, requester 3 joins
        req_data  = 32'hAA00_5500;
        req_valid = 4'b0010;
        push_grant(1, 8'h55); push_grant(3, 8'hAA);
        push_grant(1, 8'h55); push_grant(3, 8'hAA);
        wait_ready(rr);
        chk("fair_first", 32'(rr), 32'b0010);
        req_valid = 4'b1010;
        wait_ready(rr); chk("fair_2", 32'(rr), 32'b1000);
        wait_ready(rr); chk("fair_3", 32'(rr), 32'b0010);
        wait_ready(rr); chk("fair_4", 32'(rr), 32'b1000);
        req_valid = '0;
        wait_idle();

        // Spurious done tick in IDLE, then req_data change during WAIT
        manual_tick = 1'b1;
        @(negedge clk);
        manual_tick = 1'b0;
        @(negedge clk);
        chk("spur_busy", 32'(busy), 0);
        chk("spur_ready", 32'(req_ready), 0);
        req_data  = 32'h005C_0000;
        req_valid = 4'b0100;
        push_grant(2, 8'h5C);
        wait_ready(rr);
        req_valid = '0;
        req_data  = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("hold_din", 32'(tx_din), 32'h5C);
        chk("hold_busy", 32'(busy), 1);
        wait_idle();

        // Reset mid-frame
        req_data  = 32'h009D_0000;
        req_valid = 4'b0100;
        push_grant(2, 8'h9D);
        wait_ready(rr);
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_start", 32'(tx_start), 0);
        chk("mid_rst_din", 32'(tx_din), 0);
        chk("mid_rst_grant", 32'(grant_id), 0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        chk("mid_rst_quiet", 32'(busy), 0);

        // Pointer restored to NREQ-1: requester 1 beats requester 3
        req_data  = 32'hAA00_5500;
        req_valid = 4'b1010;
        push_grant(1, 8'h55);
        wait_ready(rr);
        chk("post_rst_ready", 32'(rr), 32'b0010);
        req_valid = '0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` serializer between `NREQ` byte requesters. It accepts one byte at a time through a valid/ready handshake and drives the transmitter's `tx_din`/`tx_start` inputs. It then holds off further grants until the transmitter's `tx_done_tick`. It sits between the requesting logic (command responders, status reporters) and the `uart_tx` plus `timer_input` baud generator pair.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DBIT`, 8: data bits per frame; must equal the `uart_tx` `DBIT`.
- `GW`, localparam `$clog2(NREQ)`: width of `grant_id`.

- `clk`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: bit i set means requester i has a byte pending. It must stay high until `req_ready[i]`.
- `req_data`  in  NREQ*DBIT: requester i's byte is in bits `[i*DBIT +: DBIT]`.
- `req_ready`  out  NREQ: one-cycle, one-hot pulse meaning requester i's byte was accepted.
- `tx_start`  out  1: one-cycle start pulse to `uart_tx`.
- `tx_din`  out  DBIT: byte for `uart_tx`; held stable from `tx_start` until `tx_done_tick`.
- `tx_done_tick`  in  1: end-of-frame tick from `uart_tx`.
- `busy`  out  1: high from grant until the cycle after the last `tx_done_tick` of the transaction.
- `grant_id`  out  GW: index of the current or most recent granted requester.

## Operation
- **State machine:** IDLE, SEND, WAIT. With `UART_ARB_ID_PREFIX_EN` defined, the states are IDLE, HSEND, HWAIT, SEND, WAIT.
- **IDLE:** if `req_valid != 0`, pick the first set bit searching circularly from `last_grant+1`. Then, registered:
  - latch the winner's byte into `tx_din` (or into the payload register when the prefix is enabled);
  - set `grant_id`, pulse `req_ready[winner]`, set `busy`;
  - go to SEND (HSEND with the prefix).
  - If no request is pending, stay in IDLE with all pulses low.
- **SEND:** `tx_start` is high for exactly this cycle. Go to WAIT.
- **WAIT:** hold `tx_din`. On `tx_done_tick`, update `last_grant` to `grant_id`, clear `busy`, and go to IDLE.
- **Ignored ticks:** `tx_done_tick` is ignored in IDLE, SEND and HSEND.
- **Round-robin:** after reset, `last_grant = NREQ-1`, so requester 0 has top priority first. A requester that was just served has lowest priority in the next arbitration.
- **Input sampling:** `req_data` is sampled only in the IDLE grant cycle. Changes to `req_valid` or `req_data` during SEND or WAIT have no effect.
- **Reset:** when asserted in any state (including mid-frame), the next state is IDLE. Reset values:
  - `tx_start=0`, `req_ready=0`, `tx_din=0`, `busy=0`, `grant_id=0`, `last_grant=NREQ-1`.
- **Shared reset:** the downstream `uart_tx` shares this reset. No in-flight frame is resumed after reset.

## Timing
- **Grant timing:** `req_valid[i]` is sampled high in IDLE at edge E. From E until E+1, `req_ready[i]=1`, `tx_din` is valid and the state is SEND with `tx_start=1`.
- **Single pulses:** exactly one `req_ready` pulse and one payload `tx_start` pulse per accepted byte.
- **Back-to-back:** with `tx_done_tick` at edge D and a request still pending, the next grant and `tx_start` occur one cycle after D. There is one IDLE cycle between frames. No `tx_start` is ever issued while in WAIT.
- **Request withdrawal:** dropping `req_valid` before `req_ready` is allowed; that byte is simply not sent.

## Configuration
- **`UART_ARB_ID_PREFIX_EN` defined:** each grant sends two frames.
  - First frame is the header `8'h30 + grant_id` (ASCII digit), truncated or zero-extended to `DBIT`.
  - HSEND pulses `tx_start` with the header on `tx_din`; HWAIT waits for `tx_done_tick`.
  - The next cycle goes to SEND, which loads the payload into `tx_din` and pulses `tx_start`; then WAIT.
  - `busy` stays high across both frames. `req_ready` still pulses once, at grant.
- **Not defined:** single frame per grant as described above. HSEND/HWAIT and the payload register are not synthesized.

## Test plan
- **Reset mid-frame:** reset during WAIT → next cycle IDLE, `busy=0`, `tx_start=0`, `tx_din=0`. No `tx_start` until a new request arrives.
- **Single requester:** `req_valid=4'b0100`, data `8'hA5` → one `req_ready=4'b0100` pulse and `tx_start` in the same cycle, `tx_din=8'hA5`, `grant_id=2`. The 8N1 waveform on `tx` decodes to `A5`.
- **All four requesting:** all valid with bytes `11,22,33,44` → serial order `11,22,33,44`, then `11` again if still valid. Exactly one IDLE cycle between each `tx_done_tick` and the next `tx_start`.
- **Fairness:** requester 1 holds `req_valid` continuously while requester 3 raises it → grants alternate 1,3,1,3.
- **Ignored inputs:** a spurious `tx_done_tick` in IDLE and a `req_data` change during WAIT → no state change, `tx_din` unchanged.
- **Prefix build:** with `UART_ARB_ID_PREFIX_EN` and requester 3 sending `8'h5A` → serial `33`,`5A`. Two `tx_start` pulses, one `req_ready`, and `busy` high throughout.
